// File: rtl/alu_rs_core_pkg.sv
// -----------------------------------------------------------------------------
// alu_rs_core_pkg
// Shared types and constants for the ALU reservation station.
//   RS_DEPTH      : default number of reservation-station entries
//   PREG_W        : physical register tag width
//   alu_rs_data_t : renamed ALU micro-op payload as held in one RS entry
//   is_x0         : true for the hard-wired zero register tag
// -----------------------------------------------------------------------------
package alu_rs_core_pkg;

    localparam int RS_DEPTH = 8;
    localparam int PREG_W   = 7;

    typedef struct packed {
        logic [3:0]        alu_op;
        logic [PREG_W-1:0] prd;
        logic [PREG_W-1:0] prs1;
        logic [PREG_W-1:0] prs2;
        logic              rdy1;
        logic              rdy2;
        logic [31:0]       imm;
        logic [4:0]        rob_tag;
    } alu_rs_data_t;

    // x0 is never produced by an instruction, so a source naming it is ready.
    function automatic logic is_x0(input logic [PREG_W-1:0] tag);
        return (tag == {PREG_W{1'b0}});
    endfunction

endpackage

// File: rtl/alu_rs_alloc.sv
// -----------------------------------------------------------------------------
// alu_rs_alloc
// Combinational dual lowest-free-entry finder for the reservation station.
// Ports:
//   occupied   in  DEPTH        : per-entry occupied bits
//   idx_a      out log2(DEPTH)  : lowest-index free entry (slot A)
//   idx_b      out log2(DEPTH)  : second-lowest-index free entry (slot B)
//   has_a      out 1            : slot A exists
//   has_b      out 1            : slot B exists
//   free_count out log2(DEPTH)+1: number of free entries
// -----------------------------------------------------------------------------
module alu_rs_alloc
    import alu_rs_core_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH
) (
    input  logic [DEPTH-1:0]         occupied,
    output logic [$clog2(DEPTH)-1:0] idx_a,
    output logic [$clog2(DEPTH)-1:0] idx_b,
    output logic                     has_a,
    output logic                     has_b,
    output logic [$clog2(DEPTH):0]   free_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    // Scan upward: the first free entry becomes slot A, the second slot B.
    always_comb begin
        idx_a      = {IDX_W{1'b0}};
        idx_b      = {IDX_W{1'b0}};
        has_a      = 1'b0;
        has_b      = 1'b0;
        free_count = {CNT_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (!occupied[i]) begin
                free_count = free_count + CNT_W'(1);
                if (!has_a) begin
                    has_a = 1'b1;
                    idx_a = IDX_W'(i);
                end else if (!has_b) begin
                    has_b = 1'b1;
                    idx_b = IDX_W'(i);
                end else begin
                    has_b = has_b;
                end
            end else begin
                free_count = free_count;
            end
        end
    end

endmodule

// File: rtl/alu_rs_core.sv
// -----------------------------------------------------------------------------
// alu_rs_core
// ALU reservation station: accepts up to two renamed micro-ops per cycle,
// wakes sources from CDB broadcasts and issues one ready entry per cycle.
// Optional build macro: ALU_RS_AGE_SELECT_EN (oldest-ready issue via an age
// matrix; default build issues the lowest-index ready entry).
// Tag width is taken from alu_rs_core_pkg::PREG_W.
// Ports:
//   clk          in  1               : clock
//   reset        in  1               : synchronous active-low reset
//   flush        in  1               : kills all entries at the next edge
//   disp_valid   in  2               : dispatch lane valids (lane 0 older)
//   disp_data    in  2 x alu_rs_data : dispatched micro-ops
//   disp_ready   out 1               : at least two entries free
//   cdb_valid    in  CDB_PORTS       : wakeup broadcast valids
//   cdb_preg     in  CDB_PORTS x tag : broadcast physical tags
//   issue_valid  out 1               : a ready entry is selected
//   issue_data   out alu_rs_data     : selected entry payload ('0 if none)
//   issue_ready  in  1               : ALU accepts the selected entry
//   free_count   out log2(DEPTH)+1   : unoccupied entries
// -----------------------------------------------------------------------------
module alu_rs_core
    import alu_rs_core_pkg::*;
#(
    parameter int DEPTH     = RS_DEPTH,
    parameter int CDB_PORTS = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    input  logic [1:0]                          disp_valid,
    input  alu_rs_data_t [1:0]                  disp_data,
    output logic                                disp_ready,
    input  logic [CDB_PORTS-1:0]                cdb_valid,
    input  logic [CDB_PORTS-1:0][PREG_W-1:0]    cdb_preg,
    output logic                                issue_valid,
    output alu_rs_data_t                        issue_data,
    input  logic                                issue_ready,
    output logic [$clog2(DEPTH):0]              free_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [DEPTH-1:0] occ_r;
    logic [DEPTH-1:0] occ_nxt_s;
    alu_rs_data_t     ent_r     [DEPTH];
    alu_rs_data_t     ent_nxt_s [DEPTH];

    logic [IDX_W-1:0] idx_a_s;
    logic [IDX_W-1:0] idx_b_s;
    logic             has_a_s;
    logic             has_b_s;
    logic [CNT_W-1:0] free_cnt_s;

    logic             disp_fire_s;
    logic             lane0_en_s;
    logic             lane1_en_s;
    logic [IDX_W-1:0] slot0_s;
    logic [IDX_W-1:0] slot1_s;

    logic [DEPTH-1:0] ready_s;
    logic [DEPTH-1:0] pick_s;
    logic [IDX_W-1:0] sel_idx_s;
    logic             issue_fire_s;

    // A source becomes ready if already ready, names x0, or matches any
    // valid broadcast this cycle.
    function automatic alu_rs_data_t wake(
        input alu_rs_data_t                      d,
        input logic [CDB_PORTS-1:0]              v,
        input logic [CDB_PORTS-1:0][PREG_W-1:0]  p
    );
        alu_rs_data_t r;
        r      = d;
        r.rdy1 = d.rdy1 | is_x0(d.prs1);
        r.rdy2 = d.rdy2 | is_x0(d.prs2);
        for (int k = 0; k < CDB_PORTS; k++) begin
            r.rdy1 = r.rdy1 | (v[k] & (p[k] == d.prs1));
            r.rdy2 = r.rdy2 | (v[k] & (p[k] == d.prs2));
        end
        return r;
    endfunction

    alu_rs_alloc #(
        .DEPTH (DEPTH)
    ) u_alloc (
        .occupied   (occ_r),
        .idx_a      (idx_a_s),
        .idx_b      (idx_b_s),
        .has_a      (has_a_s),
        .has_b      (has_b_s),
        .free_count (free_cnt_s)
    );

    // Free space only reflects registered occupancy, so a slot freed by this
    // cycle's issue is not offered to dispatch until the next cycle.
    assign disp_ready = has_a_s & has_b_s;
    assign free_count = free_cnt_s;

    // Dispatch lane-to-slot steering; lane 1 takes slot A when lane 0 is idle.
    always_comb begin
        disp_fire_s = disp_ready & (|disp_valid) & ~flush;
        lane0_en_s  = disp_fire_s & disp_valid[0];
        lane1_en_s  = disp_fire_s & disp_valid[1];
        slot0_s     = idx_a_s;
        if (disp_valid[0]) begin
            slot1_s = idx_b_s;
        end else begin
            slot1_s = idx_a_s;
        end
    end

`ifdef ALU_RS_AGE_SELECT_EN
    // older_r[i][j] set means entry j was allocated before entry i.
    logic [DEPTH-1:0] older_r [DEPTH];
    logic [DEPTH-1:0] freed_s;
    logic [DEPTH-1:0] lane0_oh_s;

    // One-hot masks of the entry leaving on issue and the lane-0 target.
    always_comb begin
        freed_s    = {DEPTH{1'b0}};
        lane0_oh_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            freed_s[i]    = issue_fire_s & (sel_idx_s == IDX_W'(i));
            lane0_oh_s[i] = lane0_en_s & (slot0_s == IDX_W'(i));
        end
    end

    // Age matrix: a new row records every surviving entry as older; a freed
    // entry's column is cleared so it no longer blocks anyone.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!reset || flush) begin
                older_r[i] <= {DEPTH{1'b0}};
            end else if (lane0_en_s && (slot0_s == IDX_W'(i))) begin
                older_r[i] <= occ_r & ~freed_s;
            end else if (lane1_en_s && (slot1_s == IDX_W'(i))) begin
                older_r[i] <= (occ_r & ~freed_s) | lane0_oh_s;
            end else begin
                older_r[i] <= older_r[i] & ~freed_s;
            end
        end
    end

    // Oldest ready entry: ready with no older ready entry.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready_s[i] = occ_r[i] & ent_r[i].rdy1 & ent_r[i].rdy2;
        end
        for (int i = 0; i < DEPTH; i++) begin
            pick_s[i] = ready_s[i] & ((older_r[i] & ready_s) == {DEPTH{1'b0}});
        end
    end
`else
    // Lowest-index priority: every ready entry is a candidate.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready_s[i] = occ_r[i] & ent_r[i].rdy1 & ent_r[i].rdy2;
        end
        pick_s = ready_s;
    end
`endif

    // Lowest-index candidate drives the issue port from registered state only.
    always_comb begin
        sel_idx_s   = {IDX_W{1'b0}};
        issue_valid = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (pick_s[i]) begin
                sel_idx_s   = IDX_W'(i);
                issue_valid = 1'b1;
            end else begin
                sel_idx_s = sel_idx_s;
            end
        end
        if (issue_valid) begin
            issue_data = ent_r[sel_idx_s];
        end else begin
            issue_data = '0;
        end
        issue_fire_s = issue_valid & issue_ready;
    end

    // Next occupancy: flush wins; otherwise retire the issued entry and
    // mark dispatched slots.
    always_comb begin
        occ_nxt_s = occ_r;
        if (flush) begin
            occ_nxt_s = {DEPTH{1'b0}};
        end else begin
            if (issue_fire_s) begin
                occ_nxt_s[sel_idx_s] = 1'b0;
            end else begin
                occ_nxt_s = occ_nxt_s;
            end
            if (lane0_en_s) begin
                occ_nxt_s[slot0_s] = 1'b1;
            end else begin
                occ_nxt_s = occ_nxt_s;
            end
            if (lane1_en_s) begin
                occ_nxt_s[slot1_s] = 1'b1;
            end else begin
                occ_nxt_s = occ_nxt_s;
            end
        end
    end

    // Next payload: dispatched entries are written with bypassed readiness,
    // resident entries snoop the CDB.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_nxt_s[i] = ent_r[i];
            if (lane0_en_s && (slot0_s == IDX_W'(i))) begin
                ent_nxt_s[i] = wake(disp_data[0], cdb_valid, cdb_preg);
            end else if (lane1_en_s && (slot1_s == IDX_W'(i))) begin
                ent_nxt_s[i] = wake(disp_data[1], cdb_valid, cdb_preg);
            end else begin
                ent_nxt_s[i] = wake(ent_r[i], cdb_valid, cdb_preg);
            end
        end
    end

    // Occupied bits: the only state that needs a defined reset value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            occ_r <= {DEPTH{1'b0}};
        end else begin
            occ_r <= occ_nxt_s;
        end
    end

    // Payload registers carry no reset; they are qualified by occ_r.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_r[i] <= ent_nxt_s[i];
        end
    end

endmodule
